// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of a combinational 4-bit ALU: register file, operand/opcode
// registers, flag capture and a two-state IDLE/EXEC sequencer behind a valid/ready port.
module alu_issue_ctrl #(
   parameter int WIDTH = 4,
   parameter int NREG  = 4,
   parameter int RAW   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_ld,
   input  logic [2:0]       cmd_op,
   input  logic [RAW-1:0]   cmd_rd,
   input  logic [RAW-1:0]   cmd_rs1,
   input  logic [RAW-1:0]   cmd_rs2,
   input  logic [WIDTH-1:0] cmd_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_ch,
   input  logic [WIDTH-1:0] alu_f,
   input  logic             zero_f,
   input  logic             over_f,
   input  logic             cout_f,
   output logic [2:0]       flags_q,
   output logic             done,
   output logic             illegal_q,
   input  logic [RAW-1:0]   dbg_sel,
   output logic [WIDTH-1:0] dbg_data,
   output logic             dbg_exec
);

   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   localparam logic [2:0] OP_ILLEGAL = 3'b111;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rf_q [NREG];
   logic [WIDTH-1:0] rf_d [NREG];
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_ch_q, alu_ch_d;
   logic [RAW-1:0]   rd_q, rd_d;
   logic [2:0]       flags_d;
   logic             done_q, done_d;
   logic             illegal_d;

   // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
   // cmd_valid need not be held, and cmd_* are ignored whenever ready is low.
   assign cmd_ready = (state_q == IDLE) && !rst;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_ch    = alu_ch_q;
   assign done      = done_q;
   assign dbg_data  = rf_q[dbg_sel];
   assign dbg_exec  = (state_q == EXEC);

   always_comb begin
      state_d   = state_q;
      rf_d      = rf_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_ch_d  = alu_ch_q;
      rd_d      = rd_q;
      flags_d   = flags_q;
      done_d    = 1'b0;
      illegal_d = illegal_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_ld) begin
                  rf_d[cmd_rd] = cmd_imm;
                  done_d       = 1'b1;
               end else if (cmd_op == OP_ILLEGAL) begin
                  illegal_d = 1'b1;
                  done_d    = 1'b1;
               end else begin
                  alu_a_d  = rf_q[cmd_rs1];
                  alu_b_d  = rf_q[cmd_rs2];
                  alu_ch_d = cmd_op;
                  rd_d     = cmd_rd;
                  state_d  = EXEC;
               end
            end
         end
         EXEC: begin
            // The ALU has had a full cycle to settle on the registered operands.
            rf_d[rd_q] = alu_f;
            flags_d    = {cout_f, over_f, zero_f};
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_ch_q  <= '0;
         rd_q      <= '0;
         flags_q   <= '0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rf_q      <= rf_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_ch_q  <= alu_ch_d;
         rd_q      <= rd_d;
         flags_q   <= flags_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small combinational stand-in for the 4-bit ALU.
module tb_alu_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_ld;
   logic [2:0] cmd_op;
   logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
   logic [3:0] cmd_imm;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_ch;
   logic [3:0] alu_f;
   logic       zero_f, over_f, cout_f;
   logic [2:0] flags_q;
   logic       done;
   logic       illegal_q;
   logic [1:0] dbg_sel;
   logic [3:0] dbg_data;
   logic       dbg_exec;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.WIDTH(4), .NREG(4), .RAW(2)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ld(cmd_ld), .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1),
      .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm), .alu_a(alu_a), .alu_b(alu_b),
      .alu_ch(alu_ch), .alu_f(alu_f), .zero_f(zero_f), .over_f(over_f),
      .cout_f(cout_f), .flags_q(flags_q), .done(done), .illegal_q(illegal_q),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_exec(dbg_exec)
   );

   // ALU stand-in: 000 add, 001 sub, 010 and, 011 or, 100 xor, else pass a.
   logic [4:0] sum5, diff5;
   logic [3:0] m_f;
   logic       m_c, m_o;
   always_comb begin
      sum5  = {1'b0, alu_a} + {1'b0, alu_b};
      diff5 = {1'b0, alu_a} - {1'b0, alu_b};
      m_f   = alu_a;
      m_c   = 1'b0;
      m_o   = 1'b0;
      case (alu_ch)
         3'b000: begin
            m_f = sum5[3:0];
            m_c = sum5[4];
            m_o = (alu_a[3] == alu_b[3]) && (sum5[3] != alu_a[3]);
         end
         3'b001: begin
            m_f = diff5[3:0];
            m_c = diff5[4];
            m_o = (alu_a[3] != alu_b[3]) && (diff5[3] != alu_a[3]);
         end
         3'b010:  m_f = alu_a & alu_b;
         3'b011:  m_f = alu_a | alu_b;
         3'b100:  m_f = alu_a ^ alu_b;
         default: m_f = alu_a;
      endcase
   end
   assign alu_f  = m_f;
   assign cout_f = m_c;
   assign over_f = m_o;
   assign zero_f = (m_f == 4'd0);

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rf(input string tag, input logic [1:0] idx, input logic [3:0] exp);
      dbg_sel = idx;
      #1;
      check_eq(tag, dbg_data, exp);
   endtask

   task automatic do_ld(input logic [1:0] rd, input logic [3:0] imm);
      cmd_valid = 1'b1;
      cmd_ld    = 1'b1;
      cmd_rd    = rd;
      cmd_imm   = imm;
      tick();
      cmd_valid = 1'b0;
      cmd_ld    = 1'b0;
      check_eq("ld_done", done, 1);
      check_rf("ld_rf", rd, imm);
   endtask

   task automatic do_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [3:0] exp_a, input logic [3:0] exp_b,
                        input logic [3:0] exp_r, input logic [2:0] exp_flags);
      cmd_valid = 1'b1;
      cmd_ld    = 1'b0;
      cmd_op    = op;
      cmd_rd    = rd;
      cmd_rs1   = rs1;
      cmd_rs2   = rs2;
      tick();
      check_eq("exec_ready", cmd_ready, 0);
      check_eq("exec_state", dbg_exec, 1);
      check_eq("exec_alu_a", alu_a, exp_a);
      check_eq("exec_alu_b", alu_b, exp_b);
      check_eq("exec_alu_ch", alu_ch, op);
      check_eq("exec_done", done, 0);
      // Keep valid high as a load into rs1 while in EXEC; it must not be taken.
      cmd_ld  = 1'b1;
      cmd_rd  = rs1;
      cmd_imm = 4'hf;
      tick();
      cmd_valid = 1'b0;
      cmd_ld    = 1'b0;
      check_eq("wb_done", done, 1);
      check_eq("wb_ready", cmd_ready, 1);
      check_eq("wb_flags", flags_q, exp_flags);
      check_rf("wb_rf", rd, exp_r);
      if (rd != rs1) check_rf("hold_ignored", rs1, exp_a);
      tick();
      check_eq("done_pulse_end", done, 0);
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_ld    = 1'b0;
      cmd_op    = 3'b000;
      cmd_rd    = 2'd0;
      cmd_rs1   = 2'd0;
      cmd_rs2   = 2'd0;
      cmd_imm   = 4'd0;
      dbg_sel   = 2'd0;

      tick();
      check_eq("rst_ready_low", cmd_ready, 0);
      rst = 1'b0;
      #1;
      check_eq("rst_ready", cmd_ready, 1);
      check_eq("rst_state", dbg_exec, 0);
      check_eq("rst_flags", flags_q, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_illegal", illegal_q, 0);
      check_eq("rst_alu_a", alu_a, 0);
      check_eq("rst_alu_ch", alu_ch, 0);
      for (int i = 0; i < 4; i++) check_rf("rst_rf", 2'(i), 4'd0);

      // 3 + 4 = 7, no flags
      do_ld(2'd0, 4'd3);
      do_ld(2'd1, 4'd4);
      do_op(3'b000, 2'd2, 2'd0, 2'd1, 4'd3, 4'd4, 4'd7, 3'b000);

      // 7 + 1 = 8: signed overflow, no carry
      do_ld(2'd0, 4'd7);
      do_ld(2'd1, 4'd1);
      do_op(3'b000, 2'd3, 2'd0, 2'd1, 4'd7, 4'd1, 4'd8, 3'b010);

      // 5 - 5 = 0: zero flag
      do_ld(2'd0, 4'd5);
      do_op(3'b001, 2'd1, 2'd0, 2'd0, 4'd5, 4'd5, 4'd0, 3'b001);

      // rd == rs1 == rs2 reads the old value: 5 + 5 = 10, signed overflow
      do_op(3'b000, 2'd0, 2'd0, 2'd0, 4'd5, 4'd5, 4'ha, 3'b010);

      // Back-to-back loads on consecutive cycles
      cmd_valid = 1'b1;
      cmd_ld    = 1'b1;
      cmd_rd    = 2'd2;
      cmd_imm   = 4'd9;
      tick();
      check_eq("b2b_done0", done, 1);
      check_eq("b2b_ready", cmd_ready, 1);
      cmd_rd  = 2'd3;
      cmd_imm = 4'd6;
      tick();
      cmd_valid = 1'b0;
      cmd_ld    = 1'b0;
      check_eq("b2b_done1", done, 1);
      check_rf("b2b_r2", 2'd2, 4'd9);
      check_rf("b2b_r3", 2'd3, 4'd6);
      tick();
      check_eq("b2b_done_end", done, 0);

      // Illegal opcode: sticky flag, done pulse, nothing else moves
      cmd_valid = 1'b1;
      cmd_ld    = 1'b0;
      cmd_op    = 3'b111;
      cmd_rd    = 2'd1;
      cmd_rs1   = 2'd2;
      cmd_rs2   = 2'd3;
      tick();
      cmd_valid = 1'b0;
      check_eq("ill_done", done, 1);
      check_eq("ill_flag", illegal_q, 1);
      check_eq("ill_state", dbg_exec, 0);
      check_eq("ill_ready", cmd_ready, 1);
      check_eq("ill_flags", flags_q, 3'b010);
      check_eq("ill_alu_ch", alu_ch, 3'b000);
      check_eq("ill_alu_a", alu_a, 4'd5);
      check_rf("ill_rf", 2'd1, 4'd0);
      do_ld(2'd1, 4'd4);
      check_eq("ill_sticky", illegal_q, 1);

      // Reset during EXEC discards the writeback
      cmd_valid = 1'b1;
      cmd_ld    = 1'b0;
      cmd_op    = 3'b000;
      cmd_rd    = 2'd3;
      cmd_rs1   = 2'd2;
      cmd_rs2   = 2'd1;
      tick();
      cmd_valid = 1'b0;
      check_eq("rx_exec", dbg_exec, 1);
      check_eq("rx_alu_a", alu_a, 4'd9);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check_eq("rx_done", done, 0);
      check_eq("rx_state", dbg_exec, 0);
      check_eq("rx_ready", cmd_ready, 1);
      check_eq("rx_flags", flags_q, 0);
      check_eq("rx_illegal", illegal_q, 0);
      for (int i = 0; i < 4; i++) check_rf("rx_rf", 2'(i), 4'd0);
      tick();
      check_eq("rx_no_done", done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
